// File: rtl/pim_op_sequencer.sv
// Sequences READ/PROGRAM/ERASE/BURST commands onto the PIM macro port.
// Strobe widths come from a single down-counter; read words leave on a valid/ready channel.
module pim_op_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_READ  = 2,
  parameter int unsigned T_PROG  = 10,
  parameter int unsigned T_ERASE = 50,
  parameter int unsigned T_RECOV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              done_pulse,
  output logic [ADDR_W-1:0] pim_addr,
  output logic [DATA_W-1:0] pim_wd,
  input  logic [DATA_W-1:0] pim_rd,
  output logic              pim_rd_en,
  output logic              pim_prog,
  output logic              pim_erase
);

  localparam int unsigned T_MAX_A = (T_SETUP > T_READ)  ? T_SETUP : T_READ;
  localparam int unsigned T_MAX_B = (T_PROG  > T_ERASE) ? T_PROG  : T_ERASE;
  localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_RECOV) ? T_MAX_C : T_RECOV;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;

  localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] RECOV_INIT = CNT_W'(T_RECOV - 1);
  localparam logic             RECOV_ONE  = (T_RECOV == 1);

  if (T_SETUP == 0 || T_READ == 0 || T_PROG == 0 || T_ERASE == 0 || T_RECOV == 0) begin : g_bad_timing
    $error("pim_op_sequencer: timing parameters must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_SAMPLE, S_RESP, S_RECOV
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_pim_addr;
  logic [DATA_W-1:0] r_pim_wd;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_prog;
  logic              r_erase;

  logic              w_is_rd;
  logic              w_final;
  logic [CNT_W-1:0]  w_strobe_init;

  // Final word: every non-burst op, or the burst word whose index reached the length field.
  assign w_is_rd = (r_op == OP_READ) || (r_op == OP_BURST);
  assign w_final = (r_op != OP_BURST) || (r_idx == r_len);

  always_comb begin
    w_strobe_init = CNT_W'(T_READ - 1);
    if (r_op == OP_PROG) begin
      w_strobe_init = CNT_W'(T_PROG - 1);
    end else if (r_op == OP_ERASE) begin
      w_strobe_init = CNT_W'(T_ERASE - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_READ;
      r_len       <= '0;
      r_idx       <= '0;
      r_pim_addr  <= '0;
      r_pim_wd    <= '0;
      r_rsp_data  <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_prog      <= 1'b0;
      r_erase     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_op        <= cmd_op;
            r_len       <= cmd_len;
            r_idx       <= '0;
            r_pim_addr  <= cmd_addr;
            if (cmd_op == OP_PROG) begin
              r_pim_wd <= cmd_wdata;
            end
            r_cnt   <= SETUP_INIT;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_cnt   <= w_strobe_init;
            r_rd_en <= w_is_rd;
            r_prog  <= (r_op == OP_PROG);
            r_erase <= (r_op == OP_ERASE);
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_rd_en <= 1'b0;
            r_prog  <= 1'b0;
            r_erase <= 1'b0;
            if (w_is_rd) begin
              r_state <= S_SAMPLE;
            end else begin
              r_cnt   <= RECOV_INIT;
              r_done  <= w_final && RECOV_ONE;
              r_state <= S_RECOV;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          r_rsp_data  <= pim_rd;
          r_rsp_valid <= 1'b1;
          r_rsp_last  <= w_final;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_cnt       <= RECOV_INIT;
            r_done      <= w_final && RECOV_ONE;
            r_state     <= S_RECOV;
          end
        end
        S_RECOV: begin
          // done_pulse is raised for the last recovery cycle so the next accept lands right after it.
          if (r_cnt == '0) begin
            r_done <= 1'b0;
            if (!w_final) begin
              r_idx      <= r_idx + LEN_W'(1);
              r_pim_addr <= r_pim_addr + ADDR_W'(1);
              r_cnt      <= SETUP_INIT;
              r_state    <= S_SETUP;
            end else begin
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_done <= w_final;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({r_rd_en, r_prog, r_erase}));

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_last   = r_rsp_last;
  assign busy       = r_busy;
  assign done_pulse = r_done;
  assign pim_addr   = r_pim_addr;
  assign pim_wd     = r_pim_wd;
  assign pim_rd_en  = r_rd_en;
  assign pim_prog   = r_prog;
  assign pim_erase  = r_erase;

endmodule
